// File: rtl/cm_bus_sched_pkg.sv
// ---------------------------------------------------------------------------
// cm_bus_pkg
// Shared definitions for the CM bus scheduler and anything that watches it
// (e.g. a bus-interface bench monitor).
//   ACK_CODE / NAK_CODE : reply bytes recognised during reply wait
//   status_e            : completion status reported with done
//   state_e             : 3-bit scheduler state encoding
//   ID_W                : width of requester indices (done_id, rr pointer)
//   satInc8             : 8-bit increment that sticks at 8'hFF
// ---------------------------------------------------------------------------
package cm_bus_pkg;

  localparam logic [7:0] ACK_CODE = 8'hA5;
  localparam logic [7:0] NAK_CODE = 8'h5A;

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    ST_ACK     = 2'b00,
    ST_NAK     = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    TURN  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // The timeout counter must never wrap back to zero, so it saturates.
  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cm_bus_sched_if.sv
// ---------------------------------------------------------------------------
// cm_bus_sched_if
// Groups the requester handshake and the bus-interface signals of the CM bus
// scheduler.
//   req, req_data        : requester side, driven by application logic
//   grant, done, done_id,
//   done_status, busy    : requester side, driven by the scheduler
//   bus_data_out,
//   bus_drive_en         : bus side, driven by the scheduler
//   bus_data_in          : bus side, value seen on the CM pins (already sync)
// Modports: master = the scheduler, slave = application/bus environment.
// ---------------------------------------------------------------------------
interface cm_bus_sched_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 done;
  logic [2:0]           done_id;
  logic [1:0]           done_status;
  logic                 busy;
  logic [7:0]           bus_data_out;
  logic                 bus_drive_en;
  logic [7:0]           bus_data_in;

  modport master (
    input  req, req_data, bus_data_in,
    output grant, done, done_id, done_status, busy, bus_data_out, bus_drive_en
  );

  modport slave (
    output req, req_data, bus_data_in,
    input  grant, done, done_id, done_status, busy, bus_data_out, bus_drive_en
  );

endinterface

// File: rtl/cm_bus_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: starting at i_ptr and moving upward
// (wrapping at NUM_REQ), the first set request bit wins.
//   i_req   : request vector
//   i_ptr   : search start index (always < NUM_REQ)
//   o_grant : one-hot winner (zero when no request)
//   o_idx   : index of the winner
//   o_valid : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import cm_bus_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  // Walk the offsets from the pointer; the inner loop maps each rotated
  // position back to a constant index so every select is a plain bit.
  always_comb begin
    int w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((j == w_pos) && !o_valid && i_req[j]) begin
          o_valid    = 1'b1;
          o_idx      = ID_W'(j);
          o_grant[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cm_bus_sched.sv
// ---------------------------------------------------------------------------
// cm_bus_sched
// Transaction scheduler for the shared 8-bit CM bus. Arbitrates round-robin
// between NUM_REQ requesters and walks each granted byte through
// DRIVE -> TURN -> WAIT -> RESP, with NAK-driven retries and a reply timeout.
//   clk : system clock
//   rst : synchronous active-high reset, aborts any transaction silently
//   bus : cm_bus_sched_if.master (req/req_data in, grant/done/done_id/
//         done_status/busy out, bus_data_out/bus_drive_en out, bus_data_in in)
// All outputs are registered; they are computed from the next state.
// ---------------------------------------------------------------------------
module cm_bus_sched
  import cm_bus_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DRIVE_CYCLES = 1,
  parameter int TURN_CYCLES  = 2,
  parameter int TIMEOUT      = 255,
  parameter int MAX_RETRY    = 3
) (
  input  logic           clk,
  input  logic           rst,
  cm_bus_sched_if.master bus
);

  localparam int PH_MAX = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PW-1:0]   DRIVE_LAST = PW'(DRIVE_CYCLES - 1);
  localparam logic [PW-1:0]   TURN_LAST  = PW'(TURN_CYCLES - 1);
  localparam logic [7:0]      TO_LIMIT   = 8'(TIMEOUT);
  localparam logic [2:0]      RETRY_MAX  = 3'(MAX_RETRY);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  state_e             r_state, w_stateNext;
  logic [ID_W-1:0]    r_id, w_idNext;
  logic [ID_W-1:0]    r_ptr, w_ptrNext;
  logic [2:0]         r_retryCnt, w_retryNext;
  logic [7:0]         r_toCnt, w_toNext;
  logic [PW-1:0]      r_phaseCnt, w_phaseNext;
  logic [NUM_REQ-1:0] r_grant, w_grantNext;
  logic [7:0]         r_busData, w_busDataNext;
  logic               r_done, w_doneNext;
  logic [ID_W-1:0]    r_doneId, w_doneIdNext;
  status_e            r_doneStatus, w_doneStatusNext;
  logic               r_busy, w_busyNext;
  logic               r_driveEn, w_driveEnNext;

  logic [NUM_REQ-1:0] w_arbGrant;
  logic [ID_W-1:0]    w_arbIdx;
  logic               w_arbValid;
  logic [7:0]         w_selByte;
  logic [7:0]         w_toInc;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_arbGrant),
    .o_idx   (w_arbIdx),
    .o_valid (w_arbValid)
  );

  // Byte of the arbitration winner, selected by its one-hot grant.
  always_comb begin
    w_selByte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arbGrant[i]) w_selByte = bus.req_data[i*8 +: 8];
    end
  end

  // Next-state and next-output logic. Everything holds by default; the
  // registered outputs are derived from the next state so they line up with
  // the state they describe.
  always_comb begin
    w_stateNext      = r_state;
    w_idNext         = r_id;
    w_ptrNext        = r_ptr;
    w_retryNext      = r_retryCnt;
    w_toNext         = r_toCnt;
    w_phaseNext      = r_phaseCnt;
    w_grantNext      = r_grant;
    w_busDataNext    = r_busData;
    w_doneIdNext     = r_doneId;
    w_doneStatusNext = r_doneStatus;
    w_toInc          = satInc8(r_toCnt);

    case (r_state)
      IDLE: begin
        if (w_arbValid) begin
          w_stateNext   = DRIVE;
          w_idNext      = w_arbIdx;
          w_grantNext   = w_arbGrant;
          w_busDataNext = w_selByte;
          w_retryNext   = 3'd0;
          w_toNext      = 8'd0;
          w_phaseNext   = '0;
        end
      end
      DRIVE: begin
        if (r_phaseCnt == DRIVE_LAST) begin
          w_stateNext = TURN;
          w_phaseNext = '0;
        end else begin
          w_phaseNext = r_phaseCnt + PW'(1);
        end
      end
      // Our own byte echoes back during turnaround, so bus_data_in is not
      // looked at here.
      TURN: begin
        if (r_phaseCnt == TURN_LAST) begin
          w_stateNext = WAIT;
          w_phaseNext = '0;
          w_toNext    = 8'd0;
        end else begin
          w_phaseNext = r_phaseCnt + PW'(1);
        end
      end
      // ACK/NAK are tested before the timeout so a reply landing on the
      // final WAIT cycle still counts as a reply.
      WAIT: begin
        w_toNext = w_toInc;
        if (bus.bus_data_in == ACK_CODE) begin
          w_stateNext      = RESP;
          w_doneIdNext     = r_id;
          w_doneStatusNext = ST_ACK;
        end else if (bus.bus_data_in == NAK_CODE) begin
          if (r_retryCnt < RETRY_MAX) begin
            w_stateNext = DRIVE;
            w_retryNext = r_retryCnt + 3'd1;
            w_toNext    = 8'd0;
            w_phaseNext = '0;
          end else begin
            w_stateNext      = RESP;
            w_doneIdNext     = r_id;
            w_doneStatusNext = ST_NAK;
          end
        end else if (w_toInc == TO_LIMIT) begin
          w_stateNext      = RESP;
          w_doneIdNext     = r_id;
          w_doneStatusNext = ST_TIMEOUT;
        end
      end
      RESP: begin
        w_stateNext = IDLE;
        w_grantNext = '0;
        w_ptrNext   = (r_id == LAST_ID) ? '0 : r_id + ID_W'(1);
      end
      default: begin
        w_stateNext = IDLE;
        w_grantNext = '0;
      end
    endcase

    w_doneNext    = (w_stateNext == RESP);
    w_busyNext    = (w_stateNext != IDLE);
    w_driveEnNext = (w_stateNext == DRIVE);
  end

  // State and output registers; reset drops everything to idle in one edge
  // without producing a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_id         <= '0;
      r_ptr        <= '0;
      r_retryCnt   <= 3'd0;
      r_toCnt      <= 8'd0;
      r_phaseCnt   <= '0;
      r_grant      <= '0;
      r_busData    <= 8'h00;
      r_done       <= 1'b0;
      r_doneId     <= '0;
      r_doneStatus <= ST_ACK;
      r_busy       <= 1'b0;
      r_driveEn    <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_id         <= w_idNext;
      r_ptr        <= w_ptrNext;
      r_retryCnt   <= w_retryNext;
      r_toCnt      <= w_toNext;
      r_phaseCnt   <= w_phaseNext;
      r_grant      <= w_grantNext;
      r_busData    <= w_busDataNext;
      r_done       <= w_doneNext;
      r_doneId     <= w_doneIdNext;
      r_doneStatus <= w_doneStatusNext;
      r_busy       <= w_busyNext;
      r_driveEn    <= w_driveEnNext;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.done         = r_done;
  assign bus.done_id      = r_doneId;
  assign bus.done_status  = r_doneStatus;
  assign bus.busy         = r_busy;
  assign bus.bus_data_out = r_busData;
  assign bus.bus_drive_en = r_driveEn;

endmodule

// File: tb/tb_cm_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_cm_bus_sched
// Directed bench for cm_bus_sched. Expected completions are queued as each
// request is issued; a monitor pops and compares them on every done pulse.
// ---------------------------------------------------------------------------
module tb_cm_bus_sched;
  import cm_bus_pkg::*;

  localparam int NR = 4;
  localparam int DC = 1;
  localparam int TC = 2;
  localparam int TO = 255;
  localparam int MR = 3;

  // requester 0 = 3C, 1 = 22, 2 = 33, 3 = 44
  localparam logic [31:0] DATA = 32'h4433_223C;

  typedef struct packed {
    logic [2:0] id;
    logic [1:0] status;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];
  exp_t monExp;

  always #5 clk = ~clk;

  cm_bus_sched_if #(.NUM_REQ(NR)) busIf ();

  cm_bus_sched #(
    .NUM_REQ(NR), .DRIVE_CYCLES(DC), .TURN_CYCLES(TC),
    .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic [31:0] d);
    busIf.req      = r;
    busIf.req_data = d;
  endtask

  function automatic logic [7:0] byteOf(input int id);
    logic [31:0] d;
    d = DATA;
    return d[id*8 +: 8];
  endfunction

  // Entry: first DRIVE cycle. Exit: the cycle after the reply is sampled.
  task automatic phaseRun(input logic [7:0] expByte, input logic [7:0] reply,
                          input int waitCycle);
    for (int i = 0; i < DC; i++) begin
      checkOutput("drive_en", busIf.bus_drive_en, 1);
      checkOutput("drive_data", busIf.bus_data_out, expByte);
      tick();
    end
    for (int i = 0; i < TC; i++) begin
      checkOutput("turn_en", busIf.bus_drive_en, 0);
      busIf.bus_data_in = ACK_CODE;
      tick();
    end
    for (int w = 1; w <= waitCycle; w++) begin
      checkOutput("wait_en", busIf.bus_drive_en, 0);
      checkOutput("wait_done", busIf.done, 0);
      busIf.bus_data_in = (w == waitCycle) ? reply : 8'h00;
      tick();
    end
    busIf.bus_data_in = 8'h00;
  endtask

  task automatic checkResp(input int id, input logic [1:0] status);
    logic [NR-1:0] g;
    g = NR'(1) << id;
    checkOutput("resp_done", busIf.done, 1);
    checkOutput("resp_id", busIf.done_id, id);
    checkOutput("resp_status", busIf.done_status, status);
    checkOutput("resp_grant", busIf.grant, g);
    checkOutput("resp_busy", busIf.busy, 1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_grant"}, busIf.grant, 0);
    checkOutput({tag, "_busy"}, busIf.busy, 0);
    checkOutput({tag, "_done"}, busIf.done, 0);
    checkOutput({tag, "_drive"}, busIf.bus_drive_en, 0);
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (busIf.done === 1'b1) begin
      checkOutput("done_expected", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("sb_id", busIf.done_id, monExp.id);
        checkOutput("sb_status", busIf.done_status, monExp.status);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    busIf.bus_data_in = 8'h00;
    applyStimulus('0, DATA);
    tick();
    tick();
    rst = 1'b0;
    checkIdle("reset");
    checkOutput("reset_id", busIf.done_id, 0);
    checkOutput("reset_status", busIf.done_status, 0);
    checkOutput("reset_data", busIf.bus_data_out, 8'h00);

    // Single request, ACK on the second WAIT cycle, req dropped mid-flight
    $display("[TB] single request");
    applyStimulus(4'b0001, DATA);
    expQ.push_back('{3'd0, ST_ACK});
    tick();
    checkOutput("t1_grant", busIf.grant, 4'b0001);
    checkOutput("t1_busy", busIf.busy, 1);
    applyStimulus(4'b0000, DATA);
    phaseRun(8'h3C, ACK_CODE, 2);
    checkResp(0, ST_ACK);
    tick();
    checkIdle("t1_idle");

    // Round-robin with every requester asserting, from a fresh pointer
    $display("[TB] round robin");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1111, DATA);
    for (int k = 0; k < 5; k++) begin
      int id;
      logic [NR-1:0] g;
      id = k % NR;
      g = NR'(1) << id;
      expQ.push_back('{3'(id), ST_ACK});
      tick();
      checkOutput("rr_grant", busIf.grant, g);
      phaseRun(byteOf(id), ACK_CODE, 1);
      checkResp(id, ST_ACK);
      tick();
      checkOutput("rr_gap_busy", busIf.busy, 0);
    end
    applyStimulus(4'b0000, DATA);

    // Three NAKs then ACK, then four NAKs exhausting retries
    $display("[TB] nak retry");
    applyStimulus(4'b0001, DATA);
    expQ.push_back('{3'd0, ST_ACK});
    tick();
    for (int n = 0; n < 3; n++) phaseRun(8'h3C, NAK_CODE, 1);
    phaseRun(8'h3C, ACK_CODE, 1);
    checkResp(0, ST_ACK);
    tick();
    checkOutput("nak_gap_busy", busIf.busy, 0);
    expQ.push_back('{3'd0, ST_NAK});
    tick();
    for (int n = 0; n < 4; n++) phaseRun(8'h3C, NAK_CODE, 1);
    checkResp(0, ST_NAK);
    applyStimulus(4'b0000, DATA);
    tick();
    checkIdle("nak_idle");

    // Timeout: 255 silent WAIT cycles
    $display("[TB] timeout");
    applyStimulus(4'b0100, DATA);
    expQ.push_back('{3'd2, ST_TIMEOUT});
    tick();
    phaseRun(8'h33, 8'h00, 255);
    checkResp(2, ST_TIMEOUT);
    applyStimulus(4'b0000, DATA);
    tick();
    checkIdle("to_idle");

    // ACK arriving on the very cycle the timeout would fire
    $display("[TB] ack/timeout tie");
    applyStimulus(4'b1000, DATA);
    expQ.push_back('{3'd3, ST_ACK});
    tick();
    phaseRun(8'h44, ACK_CODE, 255);
    checkResp(3, ST_ACK);

    // Normal grant after the timeout/tie runs
    applyStimulus(4'b0010, DATA);
    tick();
    checkOutput("post_to_gap", busIf.busy, 0);
    expQ.push_back('{3'd1, ST_ACK});
    tick();
    checkOutput("post_to_grant", busIf.grant, 4'b0010);
    phaseRun(8'h22, ACK_CODE, 1);
    checkResp(1, ST_ACK);

    // Reset mid-WAIT (pointer is 2 at this point), then mid-DRIVE
    $display("[TB] reset abort");
    applyStimulus(4'b1111, DATA);
    tick();
    tick();
    checkOutput("pre_rst_grant", busIf.grant, 4'b0100);
    phaseRun(8'h33, 8'h00, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("rst_wait");
    tick();
    checkOutput("rst_ptr_grant", busIf.grant, 4'b0001);
    checkOutput("rst_ptr_data", busIf.bus_data_out, 8'h3C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("rst_drive");
    applyStimulus(4'b0001, DATA);
    expQ.push_back('{3'd0, ST_ACK});
    tick();
    checkOutput("post_rst_grant", busIf.grant, 4'b0001);
    phaseRun(8'h3C, ACK_CODE, 1);
    checkResp(0, ST_ACK);
    applyStimulus(4'b0000, DATA);
    tick();
    checkIdle("final_idle");
    tick();

    checkOutput("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cm_bus_sched.md
Name: cm_bus_sched

Overview:
Transaction scheduler for the shared 8-bit CM bus interface. It arbitrates round-robin between NUM_REQ local requesters and sequences each granted byte through four phases: drive, bus turnaround, reply wait, and completion. The reply is ACK, NAK (retry) or timeout. It sits between the application logic and the bus interface (bus_data_out, bus_drive_en, bus_data_in), replacing the hard-coded send/wait state machine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DRIVE_CYCLES, 1, clk cycles bus_drive_en is held per attempt (>=1)
TURN_CYCLES, 2, idle cycles after drive before reply sampling begins (>=1)
TIMEOUT, 255, WAIT cycles without ACK/NAK before timeout (1..255)
MAX_RETRY, 3, NAK-triggered re-sends allowed per transaction (0..7)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
req  in  NUM_REQ  per-requester request; hold until own done
req_data  in  8*NUM_REQ  byte to send; requester i at bits [8i+7:8i]
grant  out  NUM_REQ  one-hot owner of current transaction
done  out  1  one-cycle completion pulse
done_id  out  3  index of completing requester (valid with done)
done_status  out  2  00 ACK, 01 NAK retries exhausted, 10 timeout
busy  out  1  high in every state except IDLE
bus_data_out  out  8  byte to bus interface
bus_drive_en  out  1  bus interface drives CM pins when high
bus_data_in  in  8  bus value, already synchronous to clk

Behaviour:
- Reset values:
  - state IDLE; grant 0; done 0; done_id 0; done_status 00; busy 0.
  - bus_drive_en 0; bus_data_out 8'h00; rr pointer 0; all counters 0.
- Reset mid-transaction: abort at the next edge, no done pulse; bus_drive_en is 0 the cycle after rst is sampled.
- All outputs are registered.
- States: IDLE, DRIVE, TURN, WAIT, RESP.
- IDLE:
  - If any req bit is set, the rr_arbiter winner is chosen. Search starts at the rr pointer and moves upward, wrapping at NUM_REQ.
  - On that edge: latch id and req_data byte, set grant, load bus_data_out, clear retry and timeout counters, go to DRIVE.
  - Request in cycle 0 -> grant and bus_drive_en high from cycle 1.
- DRIVE: bus_drive_en=1 for exactly DRIVE_CYCLES cycles, then TURN.
- TURN: bus_drive_en=0 for TURN_CYCLES cycles. bus_data_in is ignored (own echo), then WAIT.
- WAIT: bus_data_in sampled every cycle; timeout counter increments each WAIT cycle.
  - 8'hA5 -> RESP with status 00.
  - 8'h5A, retry_cnt<MAX_RETRY -> retry_cnt+1, re-enter DRIVE (same byte, timeout counter cleared).
  - 8'h5A, retry_cnt==MAX_RETRY -> RESP with status 01.
  - Any other value -> stay. If the counter reaches TIMEOUT -> RESP with status 10.
  - ACK/NAK seen on the same cycle the counter reaches TIMEOUT: ACK/NAK wins.
- RESP (one cycle):
  - done=1, with done_id/done_status valid and grant still set.
  - On exit: grant clears, rr pointer = (id+1) mod NUM_REQ, go to IDLE.
  - At least one IDLE cycle separates transactions.
- A req deassert during a transaction is ignored; the transaction completes and reports done. A requester still asserting req after its done is treated as a new request.
- Requests from non-granted requesters wait; no preemption.
- The timeout counter is 8 bits and saturates; it never wraps.

Decomposition:
- Shared package cm_bus_pkg holds:
  - ACK_CODE 8'hA5, NAK_CODE 8'h5A;
  - status encodings ST_ACK, ST_NAK, ST_TIMEOUT;
  - the 3-bit state encoding (IDLE..RESP), shared with the bus-interface bench monitor.
- One sub-module, rr_arbiter. It is combinational pick-next-from-pointer: inputs req and ptr, outputs one-hot winner and index.
- Counters, latching and the FSM stay in cm_bus_sched.

Test Plan:
1. Single request: req=4'b0001, data 8'h3C; bus returns 8'hA5 on the 2nd WAIT cycle -> bus_drive_en high for cycle 1 only, bus_data_out=8'h3C; done in RESP with done_id=0 and status 00.
2. Round-robin fairness: req=4'b1111 held continuously, always ACK -> grant order 0,1,2,3,0; each done_id matches.
3. NAK retry: bus returns 8'h5A three times then 8'hA5 -> four drive phases of 8'h3C, then status 00. Four NAKs -> four drives, then status 01.
4. Timeout: bus held at 8'h00 -> done exactly 255 WAIT cycles after WAIT entry with status 10. A new request is then granted normally.
5. Tie: 8'hA5 appears on the cycle the timeout counter reaches TIMEOUT -> status 00.
6. Reset mid-WAIT and mid-DRIVE: rst high for 1 cycle -> next cycle grant=0, bus_drive_en=0, busy=0, no done pulse; rr pointer back to 0, so requester 0 wins next.
